// File: rtl/sprite_collide_engine.sv
// Sprite hit-test, ROM addressing, two-stage pixel compositing and collision events.
// Define SCE_OTK_EN to build the OTK (charge / special attack) feature.
module sprite_collide_engine #(
    parameter int unsigned N_ENM      = 3,
    parameter int unsigned SPR_W      = 40,
    parameter int unsigned SPR_H      = 30,
    parameter int unsigned MIS_W      = 56,
    parameter int unsigned MIS_H      = 12,
    parameter int unsigned HOLD_BITS  = 20,
    parameter int unsigned OTK_THRESH = 10,
    parameter int unsigned OTK_CD     = 200,
    parameter int unsigned OTK_GAP    = 20,
    parameter logic [11:0] TRANSP     = 12'hfff
) (
    input  logic                  clk_25Hz,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [9:0]            h_cnt,
    input  logic [9:0]            v_cnt,
    input  logic [10*N_ENM-1:0]   enm_x,
    input  logic [10*N_ENM-1:0]   enm_y,
    input  logic [N_ENM-1:0]      enm_valid,
    input  logic [9:0]            plr_x,
    input  logic [9:0]            plr_y,
    input  logic                  plr_valid,
    input  logic [9:0]            mis_x,
    input  logic [9:0]            mis_y,
    input  logic                  mis_valid,
    output logic [12*N_ENM-1:0]   enm_addr,
    output logic [11:0]           plr_addr,
    output logic [11:0]           mis_addr,
    output logic [14:0]           bg_addr,
    input  logic [12*N_ENM-1:0]   enm_pix,
    input  logic [11:0]           plr_pix,
    input  logic [11:0]           mis_pix,
    input  logic [11:0]           bg_pix,
    output logic [11:0]           pixel,
    output logic [N_ENM:0]        events,
    output logic                  otk_sign
);
    localparam logic [11:0] SW  = 12'(SPR_W);
    localparam logic [11:0] SH  = 12'(SPR_H);
    localparam logic [11:0] MW  = 12'(MIS_W);
    localparam logic [11:0] MH  = 12'(MIS_H);
    localparam logic [11:0] GAP = 12'(OTK_GAP);

    logic                   otk_active;
    logic [11:0]            hx, vy;
    logic [N_ENM-1:0]       enm_hit_c;
    logic [12*N_ENM-1:0]    enm_addr_c;
    logic                   plr_hit_c, mis_hit_c;
    logic [11:0]            plr_addr_c, mis_addr_c;
    logic [14:0]            bg_addr_c;
    logic [2:0]             copy_en;
    logic [11:0]            copy_y [3];

    logic [N_ENM-1:0]       enm_hit_q;
    logic                   plr_hit_q, mis_hit_q;
    logic [11:0]            colour;
    logic                   enm_found;
    logic [N_ENM:0]         die;
    logic [HOLD_BITS-1:0]   hold, hold_inc;

    // 12-bit compares keep x+W from wrapping at the right/bottom screen edge.
    function automatic logic in_span(input logic [11:0] p, input logic [11:0] org,
                                     input logic [11:0] len);
        return (p >= org) && (p < org + len);
    endfunction

    assign hx = {2'b00, h_cnt};
    assign vy = {2'b00, v_cnt};

    always_comb begin
        enm_hit_c  = '0;
        enm_addr_c = '0;
        for (int unsigned i = 0; i < N_ENM; i++) begin
            if (enm_valid[i] && in_span(hx, {2'b00, enm_x[10*i +: 10]}, SW)
                             && in_span(vy, {2'b00, enm_y[10*i +: 10]}, SH)) begin
                enm_hit_c[i] = 1'b1;
                enm_addr_c[12*i +: 12] = (vy - {2'b00, enm_y[10*i +: 10]}) * SW
                                       + (hx - {2'b00, enm_x[10*i +: 10]});
            end
        end

        plr_hit_c  = plr_valid && in_span(hx, {2'b00, plr_x}, SW) && in_span(vy, {2'b00, plr_y}, SH);
        plr_addr_c = plr_hit_c ? (vy - {2'b00, plr_y}) * SW + (hx - {2'b00, plr_x}) : '0;

        // Copy 0 is the real missile; copies 1/2 are the OTK clones below/above it.
        copy_en[0] = mis_valid;
        copy_y[0]  = {2'b00, mis_y};
        copy_en[1] = mis_valid && otk_active;
        copy_y[1]  = {2'b00, mis_y} + GAP;
        copy_en[2] = mis_valid && otk_active && ({2'b00, mis_y} >= GAP);
        copy_y[2]  = {2'b00, mis_y} - GAP;

        mis_hit_c  = 1'b0;
        mis_addr_c = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (copy_en[k] && in_span(hx, {2'b00, mis_x}, MW) && in_span(vy, copy_y[k], MH)) begin
                mis_hit_c  = 1'b1;
                mis_addr_c = (vy - copy_y[k]) * MW + (hx - {2'b00, mis_x});
            end
        end

        bg_addr_c = 15'(v_cnt[9:2]) * 15'd160 + 15'(h_cnt[9:2]);
    end

    always_ff @(posedge clk_25Hz) begin
        if (!rst) begin
            enm_addr  <= '0;
            plr_addr  <= '0;
            mis_addr  <= '0;
            bg_addr   <= '0;
            enm_hit_q <= '0;
            plr_hit_q <= 1'b0;
            mis_hit_q <= 1'b0;
        end else begin
            enm_addr  <= enm_addr_c;
            plr_addr  <= plr_addr_c;
            mis_addr  <= mis_addr_c;
            bg_addr   <= bg_addr_c;
            enm_hit_q <= enm_hit_c;
            plr_hit_q <= plr_hit_c;
            mis_hit_q <= mis_hit_c;
        end
    end

    always_comb begin
        colour    = TRANSP;
        enm_found = 1'b0;
        if (mis_hit_q) begin
            colour = mis_pix;
        end else if (plr_hit_q && |enm_hit_q) begin
            colour = TRANSP;
        end else if (plr_hit_q) begin
            colour = plr_pix;
        end else begin
            for (int unsigned i = 0; i < N_ENM; i++) begin
                if (!enm_found && enm_hit_q[i]) begin
                    colour    = enm_pix[12*i +: 12];
                    enm_found = 1'b1;
                end
            end
        end
        if (colour == TRANSP) colour = bg_pix;

        die    = '0;
        die[0] = plr_hit_q && |enm_hit_q;
        for (int unsigned i = 0; i < N_ENM; i++)
            die[i+1] = enm_hit_q[i] && (mis_hit_q || plr_hit_q);
    end

    assign hold_inc = hold + HOLD_BITS'(1);

    always_ff @(posedge clk_25Hz) begin
        if (!rst) begin
            pixel  <= '0;
            events <= '0;
            hold   <= '0;
        end else begin
            pixel <= colour;
            if (die != '0 && die != events) begin
                events <= die;
                hold   <= '0;
            end else if (!hold[HOLD_BITS-1]) begin
                hold <= hold_inc;
                if (hold_inc[HOLD_BITS-1]) events <= '0;
            end
        end
    end

`ifdef SCE_OTK_EN
    localparam int unsigned CD_W     = $clog2(OTK_CD + 1);
    localparam logic [CD_W-1:0] CD_LAST = CD_W'(OTK_CD - 1);
    localparam logic [4:0]  THRESH5  = 5'(OTK_THRESH);

    typedef enum logic {CHARGE, ACTIVE} otk_state_t;

    otk_state_t       state, state_nx;
    logic [3:0]       score, score_nx, kills;
    logic [4:0]       sum;
    logic [CD_W-1:0]  cd, cd_nx;

    always_ff @(posedge clk_25Hz) begin
        if (!rst) begin
            state <= CHARGE;
            score <= '0;
            cd    <= '0;
        end else begin
            state <= state_nx;
            score <= score_nx;
            cd    <= cd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        score_nx = score;
        cd_nx    = cd;
        kills    = '0;
        for (int unsigned i = 0; i < N_ENM; i++)
            kills = kills + 4'(events[i+1]);
        sum = {1'b0, score} + {1'b0, kills};
        if (tick) begin
            if (events[0]) begin
                state_nx = CHARGE;
                score_nx = '0;
                cd_nx    = '0;
            end else if (state == CHARGE) begin
                if ({1'b0, score} >= THRESH5) begin
                    state_nx = ACTIVE;
                    score_nx = '0;
                    cd_nx    = '0;
                end else begin
                    score_nx = sum[4] ? 4'hf : sum[3:0];
                end
            end else if (cd == CD_LAST) begin
                state_nx = CHARGE;
                score_nx = '0;
                cd_nx    = '0;
            end else begin
                cd_nx = cd + CD_W'(1);
            end
        end
    end

    assign otk_active = (state == ACTIVE);
    assign otk_sign   = otk_active;
`else
    logic unused_tick;
    assign unused_tick = tick;
    assign otk_active  = 1'b0;
    assign otk_sign    = 1'b0;
`endif

endmodule
